// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I main controller: FETCH/DECODE/EXEC/MEM/WB sequencer with illegal-opcode and memory-timeout traps.
// Latency: strobes are combinational from registered state; BEQ 3, R/OP-IMM/SW 4, LW 5 cycles minimum.
// Backpressure: FETCH and MEM hold on mem_ready=0; MEM_WAIT_MAX consecutive stalls trap to TRAP.
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   opcode                   IR[6:0], sampled only in DECODE
//   mem_ready, zero          memory completion handshake, ALU zero flag (BEQ)
//   pc_write .. reg_write    datapath strobes and mux selects
//   illegal_op, mem_timeout  sticky trap flags, cleared only by reset
//   state_dbg                current state encoding
module multicycle_control_fsm #(
    parameter int OPCODE_W     = 7,
    parameter int ALU_OP_W     = 2,
    parameter int MEM_WAIT_MAX = 15,
    parameter int HAS_ITYPE    = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    input  logic                zero,
    output logic                pc_write,
    output logic                pc_src,
    output logic                ir_write,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic                illegal_op,
    output logic                mem_timeout,
    output logic [2:0]          state_dbg
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd5;

    localparam logic [OPCODE_W-1:0] OP_LW  = OPCODE_W'(7'b0000011);
    localparam logic [OPCODE_W-1:0] OP_SW  = OPCODE_W'(7'b0100011);
    localparam logic [OPCODE_W-1:0] OP_BEQ = OPCODE_W'(7'b1100011);
    localparam logic [OPCODE_W-1:0] OP_R   = OPCODE_W'(7'b0110011);
    localparam logic [OPCODE_W-1:0] OP_IMM = OPCODE_W'(7'b0010011);

    localparam logic [7:0] WAIT_MAX = 8'(MEM_WAIT_MAX);

    logic [2:0]          state_q, state_d;
    logic [OPCODE_W-1:0] op_q, op_d;
    logic [7:0]          wait_q, wait_d;
    logic                illegal_q, illegal_d;
    logic                timeout_q, timeout_d;

    logic                dec_legal;
    logic [7:0]          wait_inc;

    assign dec_legal = (opcode == OP_LW) || (opcode == OP_SW) || (opcode == OP_BEQ) ||
                       (opcode == OP_R)  || ((HAS_ITYPE != 0) && (opcode == OP_IMM));
    assign wait_inc  = wait_q + 8'd1;

    // Next-state logic. The wait counter is zero outside FETCH/MEM, so it is
    // already clear whenever one of those states is entered.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        wait_d    = '0;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        case (state_q)
            S_FETCH, S_MEM: begin
                if (mem_ready) begin
                    if (state_q == S_FETCH)   state_d = S_DECODE;
                    else if (op_q == OP_LW)   state_d = S_WB;
                    else                      state_d = S_FETCH;
                end else if (wait_inc >= WAIT_MAX) begin
                    timeout_d = 1'b1;
                    state_d   = S_TRAP;
                end else begin
                    wait_d = wait_inc;
                end
            end
            S_DECODE: begin
                op_d = opcode;
                if (dec_legal) begin
                    state_d = S_EXEC;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = S_TRAP;
                end
            end
            S_EXEC: begin
                if ((op_q == OP_LW) || (op_q == OP_SW)) state_d = S_MEM;
                else if (op_q == OP_BEQ)                state_d = S_FETCH;
                else                                    state_d = S_WB;
            end
            S_WB:    state_d = S_FETCH;
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;   // unused codes 6/7
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            op_q      <= '0;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    // Strobe decode. Gated by rst so FETCH's read request does not appear
    // while reset is held.
    always_comb begin
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        ir_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = '0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    pc_write  = mem_ready;
                    ir_write  = mem_ready;
                end
                S_EXEC: begin
                    alu_src_a = 1'b1;
                    if ((op_q == OP_LW) || (op_q == OP_SW)) begin
                        alu_src_b = 2'b10;
                    end else if (op_q == OP_BEQ) begin
                        alu_op   = ALU_OP_W'(2'b01);
                        pc_src   = 1'b1;
                        pc_write = zero;
                    end else if (op_q == OP_IMM) begin
                        alu_src_b = 2'b10;
                        alu_op    = ALU_OP_W'(2'b11);
                    end else begin
                        alu_op = ALU_OP_W'(2'b10);
                    end
                end
                S_MEM: begin
                    i_or_d    = 1'b1;
                    mem_read  = (op_q == OP_LW);
                    mem_write = (op_q != OP_LW);
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = (op_q == OP_LW);
                end
                default: ;
            endcase
        end
    end

    assign illegal_op  = illegal_q;
    assign mem_timeout = timeout_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: two instances (default, and HAS_ITYPE=0 / MEM_WAIT_MAX=4)
// share all inputs; directed table, hand sequences and random stimulus vs a route-based model.
// Output vector order: pw ps iw id mr mw a b[1:0] op[1:0] m2r rw ill to st[2:0].
module tb_multicycle_control_fsm;

    logic       clk;
    logic       rst;
    logic [6:0] opcode;
    logic       mem_ready;
    logic       zero;

    logic       a_pw, a_ps, a_iw, a_id, a_mr, a_mw, a_sa, a_m2r, a_rw, a_ill, a_to;
    logic [1:0] a_sb, a_op;
    logic [2:0] a_st;
    logic       b_pw, b_ps, b_iw, b_id, b_mr, b_mw, b_sa, b_m2r, b_rw, b_ill, b_to;
    logic [1:0] b_sb, b_op;
    logic [2:0] b_st;

    multicycle_control_fsm u_dut_a (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready), .zero(zero),
        .pc_write(a_pw), .pc_src(a_ps), .ir_write(a_iw), .i_or_d(a_id),
        .mem_read(a_mr), .mem_write(a_mw), .alu_src_a(a_sa), .alu_src_b(a_sb),
        .alu_op(a_op), .mem_to_reg(a_m2r), .reg_write(a_rw), .illegal_op(a_ill),
        .mem_timeout(a_to), .state_dbg(a_st)
    );

    multicycle_control_fsm #(.MEM_WAIT_MAX(4), .HAS_ITYPE(0)) u_dut_b (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready), .zero(zero),
        .pc_write(b_pw), .pc_src(b_ps), .ir_write(b_iw), .i_or_d(b_id),
        .mem_read(b_mr), .mem_write(b_mw), .alu_src_a(b_sa), .alu_src_b(b_sb),
        .alu_op(b_op), .mem_to_reg(b_m2r), .reg_write(b_rw), .illegal_op(b_ill),
        .mem_timeout(b_to), .state_dbg(b_st)
    );

    logic [17:0] a_out, b_out;
    assign a_out = {a_pw, a_ps, a_iw, a_id, a_mr, a_mw, a_sa, a_sb, a_op, a_m2r, a_rw, a_ill, a_to, a_st};
    assign b_out = {b_pw, b_ps, b_iw, b_id, b_mr, b_mw, b_sa, b_sb, b_op, b_m2r, b_rw, b_ill, b_to, b_st};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [6:0] O_LW  = 7'b0000011;
    localparam logic [6:0] O_SW  = 7'b0100011;
    localparam logic [6:0] O_BEQ = 7'b1100011;
    localparam logic [6:0] O_R   = 7'b0110011;
    localparam logic [6:0] O_I   = 7'b0010011;

    localparam logic [17:0] F_RDY  = 18'b1_0_1_0_1_0_0_01_00_0_0_0_0_000;
    localparam logic [17:0] F_WAIT = 18'b0_0_0_0_1_0_0_01_00_0_0_0_0_000;
    localparam logic [17:0] DEC    = 18'b0_0_0_0_0_0_0_00_00_0_0_0_0_001;
    localparam logic [17:0] EX_R   = 18'b0_0_0_0_0_0_1_00_10_0_0_0_0_010;
    localparam logic [17:0] WB_R   = 18'b0_0_0_0_0_0_0_00_00_0_1_0_0_100;
    localparam logic [17:0] EX_BZ1 = 18'b1_1_0_0_0_0_1_00_01_0_0_0_0_010;
    localparam logic [17:0] EX_BZ0 = 18'b0_1_0_0_0_0_1_00_01_0_0_0_0_010;
    localparam logic [17:0] EX_LS  = 18'b0_0_0_0_0_0_1_10_00_0_0_0_0_010;
    localparam logic [17:0] MEM_LW = 18'b0_0_0_1_1_0_0_00_00_0_0_0_0_011;
    localparam logic [17:0] WB_LW  = 18'b0_0_0_0_0_0_0_00_00_1_1_0_0_100;
    localparam logic [17:0] TR_ILL = 18'b0_0_0_0_0_0_0_00_00_0_0_1_0_101;
    localparam logic [17:0] TR_TO  = 18'b0_0_0_0_0_0_0_00_00_0_0_0_1_101;
    localparam logic [17:0] ALL0   = 18'b0;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [17:0] act, input logic [17:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %05h expected %05h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: each instruction is a route of phases (0 fetch, 1 decode,
    // 2 exec, 3 mem, 4 wb, 5 trap). Phases 0 and 3 wait on mem_ready.
    bit         has_it [2];
    int         wmax   [2];
    int         ph     [2];
    logic [6:0] lop    [2];
    int         nwait  [2];
    bit         fl_ill [2];
    bit         fl_to  [2];
    int         rt     [2][3];
    int         rt_n   [2];
    int         rt_i   [2];

    task automatic mdl_reset_one(input int k);
        ph[k] = 0; lop[k] = '0; nwait[k] = 0; fl_ill[k] = 0; fl_to[k] = 0;
        rt_n[k] = 0; rt_i[k] = 0;
    endtask

    task automatic mdl_reset();
        mdl_reset_one(0);
        mdl_reset_one(1);
    endtask

    task automatic next_phase(input int k);
        nwait[k] = 0;
        if (ph[k] == 0) ph[k] = 1;
        else if (rt_i[k] < rt_n[k]) begin
            ph[k] = rt[k][rt_i[k]];
            rt_i[k]++;
        end else ph[k] = 0;
    endtask

    task automatic mdl_step(input int k);
        if (rst) mdl_reset_one(k);
        else if (ph[k] == 5) ;
        else if (ph[k] == 0 || ph[k] == 3) begin
            if (mem_ready) next_phase(k);
            else begin
                nwait[k]++;
                if (nwait[k] >= wmax[k]) begin fl_to[k] = 1; ph[k] = 5; end
            end
        end else if (ph[k] == 1) begin
            lop[k] = opcode;
            rt_i[k] = 0;
            rt_n[k] = 0;
            case (opcode)
                O_LW:  begin rt[k][0] = 2; rt[k][1] = 3; rt[k][2] = 4; rt_n[k] = 3; end
                O_SW:  begin rt[k][0] = 2; rt[k][1] = 3; rt_n[k] = 2; end
                O_BEQ: begin rt[k][0] = 2; rt_n[k] = 1; end
                O_R:   begin rt[k][0] = 2; rt[k][1] = 4; rt_n[k] = 2; end
                O_I:   if (has_it[k]) begin rt[k][0] = 2; rt[k][1] = 4; rt_n[k] = 2; end
                default: ;
            endcase
            if (rt_n[k] == 0) begin fl_ill[k] = 1; ph[k] = 5; end
            else next_phase(k);
        end else next_phase(k);
    endtask

    function automatic logic [17:0] mdl_out(input int k);
        logic pw, ps, iw, id, mr, mw, sa, m2r, rw;
        logic [1:0] sb, op;
        pw = 0; ps = 0; iw = 0; id = 0; mr = 0; mw = 0; sa = 0; m2r = 0; rw = 0;
        sb = 2'b00; op = 2'b00;
        if (!rst) begin
            case (ph[k])
                0: begin mr = 1; sb = 2'b01; pw = mem_ready; iw = mem_ready; end
                2: begin
                    sa = 1;
                    case (lop[k])
                        O_LW, O_SW: sb = 2'b10;
                        O_R:        op = 2'b10;
                        O_I:        begin sb = 2'b10; op = 2'b11; end
                        O_BEQ:      begin op = 2'b01; ps = 1; pw = zero; end
                        default: ;
                    endcase
                end
                3: begin id = 1; if (lop[k] == O_LW) mr = 1; else mw = 1; end
                4: begin rw = 1; m2r = (lop[k] == O_LW); end
                default: ;
            endcase
        end
        return {pw, ps, iw, id, mr, mw, sa, sb, op, m2r, rw, fl_ill[k], fl_to[k], 3'(ph[k])};
    endfunction

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic cyc(input bit use_tab, input logic [17:0] texp, input string nm);
        @(negedge clk);
        if (use_tab) check(nm, a_out, texp);
        check("model_a", a_out, mdl_out(0));
        check("model_b", b_out, mdl_out(1));
        @(posedge clk);
        mdl_step(0);
        mdl_step(1);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mdl_reset();
        cyc(1'b1, ALL0, "reset_outputs");
        rst = 1'b0;
    endtask

    typedef struct {
        logic [6:0]  op;
        logic        rdy;
        logic        z;
        logic [17:0] exp;
        string       nm;
    } vec_t;

    vec_t tab [19];

    initial begin
        has_it[0] = 1; has_it[1] = 0;
        wmax[0]   = 15; wmax[1] = 4;
        rst = 1'b1; opcode = '0; mem_ready = 1'b0; zero = 1'b0;
        mdl_reset();

        tab[0]  = '{O_R,   1'b1, 1'b0, F_RDY,  "r_fetch"};
        tab[1]  = '{O_R,   1'b1, 1'b0, DEC,    "r_decode"};
        tab[2]  = '{O_R,   1'b1, 1'b0, EX_R,   "r_exec"};
        tab[3]  = '{O_R,   1'b1, 1'b0, WB_R,   "r_wb"};
        tab[4]  = '{O_BEQ, 1'b1, 1'b1, F_RDY,  "beq1_fetch"};
        tab[5]  = '{O_BEQ, 1'b1, 1'b1, DEC,    "beq1_decode"};
        tab[6]  = '{O_BEQ, 1'b1, 1'b1, EX_BZ1, "beq1_exec"};
        tab[7]  = '{O_BEQ, 1'b1, 1'b0, F_RDY,  "beq0_fetch"};
        tab[8]  = '{O_BEQ, 1'b1, 1'b0, DEC,    "beq0_decode"};
        tab[9]  = '{O_BEQ, 1'b1, 1'b0, EX_BZ0, "beq0_exec"};
        tab[10] = '{O_LW,  1'b1, 1'b0, F_RDY,  "lw_fetch"};
        tab[11] = '{O_LW,  1'b1, 1'b0, DEC,    "lw_decode"};
        tab[12] = '{O_LW,  1'b1, 1'b0, EX_LS,  "lw_exec"};
        tab[13] = '{O_LW,  1'b0, 1'b0, MEM_LW, "lw_mem_w1"};
        tab[14] = '{O_LW,  1'b0, 1'b0, MEM_LW, "lw_mem_w2"};
        tab[15] = '{O_LW,  1'b0, 1'b0, MEM_LW, "lw_mem_w3"};
        tab[16] = '{O_LW,  1'b1, 1'b0, MEM_LW, "lw_mem_done"};
        tab[17] = '{O_LW,  1'b1, 1'b0, WB_LW,  "lw_wb"};
        tab[18] = '{O_LW,  1'b1, 1'b0, F_RDY,  "lw_next_fetch"};

        #1;
        cyc(1'b1, ALL0, "reset_hold0");
        cyc(1'b1, ALL0, "reset_hold1");
        rst = 1'b0;

        for (int i = 0; i < 19; i++) begin
            opcode = tab[i].op; mem_ready = tab[i].rdy; zero = tab[i].z;
            cyc(1'b1, tab[i].exp, tab[i].nm);
        end

        // Illegal opcode traps both instances; strobes stay low whatever the inputs.
        opcode = 7'b1111111; mem_ready = 1'b1;
        cyc(1'b0, ALL0, "");
        cyc(1'b0, ALL0, "");
        check("illegal_trap_a", a_out, TR_ILL);
        for (int i = 0; i < 4; i++) begin
            opcode = 7'($urandom); mem_ready = 1'($urandom); zero = 1'($urandom);
            cyc(1'b1, TR_ILL, "trap_hold_a");
        end
        do_reset();

        // OP-IMM: legal on instance A, illegal on instance B.
        opcode = O_I; mem_ready = 1'b1;
        cyc(1'b0, ALL0, "");
        cyc(1'b0, ALL0, "");
        check("opimm_illegal_b", b_out, TR_ILL);
        check("opimm_exec_a_state", {15'b0, a_st}, 18'd2);
        cyc(1'b1, 18'b0_0_0_0_0_0_1_10_11_0_0_0_0_010, "opimm_exec_a");
        cyc(1'b1, WB_R, "opimm_wb_a");
        do_reset();

        // Fetch stall: instance B (limit 4) traps on the 4th stalled cycle.
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) cyc(1'b0, ALL0, "");
        check("timeout_trap_b", b_out, TR_TO);
        check("no_timeout_a", a_out, F_WAIT);
        do_reset();
        // Ready on the 4th cycle wins over the timeout.
        for (int i = 0; i < 3; i++) cyc(1'b0, ALL0, "");
        mem_ready = 1'b1;
        cyc(1'b0, ALL0, "");
        check("ready_on_limit_b", b_out, DEC);
        do_reset();

        // Reset pulsed during SW memory phase.
        opcode = O_SW; mem_ready = 1'b1;
        cyc(1'b0, ALL0, "");
        cyc(1'b0, ALL0, "");
        cyc(1'b1, EX_LS, "sw_exec");
        mem_ready = 1'b0;
        cyc(1'b1, 18'b0_0_0_1_0_1_0_00_00_0_0_0_0_011, "sw_mem");
        #2;
        rst = 1'b1;
        mdl_reset();
        #1;
        check("sw_reset_drop", a_out, ALL0);
        cyc(1'b1, ALL0, "sw_reset_hold");
        rst = 1'b0;
        #1;
        check("after_release", a_out, F_WAIT);
        cyc(1'b1, F_WAIT, "after_release_cyc");

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 7))
                0: opcode = O_LW;
                1: opcode = O_SW;
                2: opcode = O_BEQ;
                3: opcode = O_R;
                4: opcode = O_I;
                5: opcode = O_R;
                6: opcode = O_LW;
                default: opcode = 7'($urandom);
            endcase
            mem_ready = ($urandom_range(0, 9) < 6);
            zero = 1'($urandom);
            if (rst) rst = ($urandom_range(0, 2) == 0);
            else if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                mdl_reset();
            end
            cyc(1'b0, ALL0, "");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
